// File: rtl/cfeb_rx_pkg.sv
// Shared types and defaults for the CFEB readout receiver.
package cfeb_rx_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RECV    = 2'd1,
        DISCARD = 2'd2
    } rx_state_e;

    localparam int ADDR_W_DEF    = 11;
    localparam int MAX_WORDS_DEF = 1540;
    localparam int EXP_WORDS_DEF = 1537;

    // 16-bit data word plus the checksum-word marker.
    localparam int ENTRY_W = 17;

endpackage

// File: rtl/cfeb_dmb_rx_if.sv
// Stream-in / FIFO-read bus between the CFEB stream source, the receiver
// and the DMB event builder.
interface cfeb_dmb_rx_if;

    logic [15:0] DIN;
    logic        LPUSH_B;
    logic        ENDWORD;
    logic        RD_EN;
    logic [15:0] DOUT;
    logic        DOUT_LAST;
    logic        EMPTY;
    logic        FULL;

    modport master (
        output DIN, LPUSH_B, ENDWORD, RD_EN,
        input  DOUT, DOUT_LAST, EMPTY, FULL
    );

    modport slave (
        input  DIN, LPUSH_B, ENDWORD, RD_EN,
        output DOUT, DOUT_LAST, EMPTY, FULL
    );

endinterface

// File: rtl/cfeb_rx_fifo.sv
// Synchronous FIFO with a registered read port. Pointers carry one extra
// bit so full and empty are told apart by the difference alone.
module cfeb_rx_fifo
    import cfeb_rx_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               WE,
    input  logic [ENTRY_W-1:0] WD,
    input  logic               RE,
    output logic [ENTRY_W-1:0] RD,
    output logic               EMPTY,
    output logic               FULL,
    output logic [ADDR_W:0]    COUNT
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [ADDR_W:0]    wptr;
    logic [ADDR_W:0]    rptr;
    logic               do_wr;
    logic               do_rd;

    assign COUNT = wptr - rptr;
    assign EMPTY = (COUNT == '0);
    assign FULL  = (COUNT == (ADDR_W+1)'(DEPTH));
    assign do_rd = RE && !EMPTY;
    // A read in the same cycle frees a slot, so a write is still safe when full.
    assign do_wr = WE && (!FULL || do_rd);

    // Pointer update; reset discards whatever was stored.
    always_ff @(posedge CLK) begin
        if (RST) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_wr) wptr <= wptr + 1'b1;
            if (do_rd) rptr <= rptr + 1'b1;
        end
    end

    // Storage array, no reset needed.
    always_ff @(posedge CLK) begin
        if (do_wr) mem[wptr[ADDR_W-1:0]] <= WD;
    end

    // Registered read data; holds when no read is taken.
    always_ff @(posedge CLK) begin
        if (RST)        RD <= '0;
        else if (do_rd) RD <= mem[rptr[ADDR_W-1:0]];
    end

endmodule

// File: rtl/cfeb_dmb_rx.sv
// CFEB readout receiver: frames the pushed word stream on ENDWORD, checks the
// trailing XOR checksum and stores whole frames in a FIFO for the DMB event
// builder. A frame is admitted only if MAX_WORDS slots are free at its first
// word; otherwise it is consumed and dropped entirely.
// Optional build macro CFEB_RX_LENCHK_EN adds EXP_WORDS and the LEN_ERR pulse.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | between frames; next push is a first word, admission decided
// RECV    | admitted frame in progress; words written, checksum folded
// DISCARD | rejected frame in progress; pushes consumed until ENDWORD
module cfeb_dmb_rx
    import cfeb_rx_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int MAX_WORDS = MAX_WORDS_DEF
`ifdef CFEB_RX_LENCHK_EN
    ,
    parameter int EXP_WORDS = EXP_WORDS_DEF
`endif
) (
    input  logic        CLK,
    input  logic        RST,
    cfeb_dmb_rx_if.slave bus,
    output logic        FRAME_OK,
    output logic        CRC_ERR,
    output logic        DROP,
    output logic [7:0]  FRAME_CNT
`ifdef CFEB_RX_LENCHK_EN
    ,
    output logic        LEN_ERR
`endif
);

    localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(1 << ADDR_W);
    localparam logic [ADDR_W:0] MAX_W   = (ADDR_W+1)'(MAX_WORDS);

    rx_state_e          state_q;
    rx_state_e          state_d;
    logic [15:0]        chk_q;
    logic               push;
    logic               admit;
    logic [ADDR_W:0]    fifo_count;
    logic [ADDR_W:0]    free_slots;
    logic [ENTRY_W-1:0] fifo_rd;
    logic               fifo_we;
    logic               start_frame;
    logic               cont_frame;
    logic               end_accept;
    logic               end_drop;
    logic               csum_good;

    assign push       = !bus.LPUSH_B;
    assign free_slots = DEPTH_W - fifo_count;
    assign admit      = (free_slots >= MAX_W);

    cfeb_rx_fifo #(.ADDR_W(ADDR_W)) u_fifo (
        .CLK   (CLK),
        .RST   (RST),
        .WE    (fifo_we),
        .WD    ({bus.ENDWORD, bus.DIN}),
        .RE    (bus.RD_EN),
        .RD    (fifo_rd),
        .EMPTY (bus.EMPTY),
        .FULL  (bus.FULL),
        .COUNT (fifo_count)
    );

    assign bus.DOUT      = fifo_rd[15:0];
    assign bus.DOUT_LAST = fifo_rd[16];

    // FSM state register.
    always_ff @(posedge CLK) begin
        if (RST) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // FSM next-state: admission is decided only on the first word of a frame.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (push) begin
                    if (bus.ENDWORD) state_d = IDLE;
                    else if (admit)  state_d = RECV;
                    else             state_d = DISCARD;
                end
            end
            RECV, DISCARD: begin
                if (push && bus.ENDWORD) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: FIFO write strobe and frame events for the registered pulses.
    always_comb begin
        fifo_we     = 1'b0;
        start_frame = 1'b0;
        cont_frame  = 1'b0;
        end_accept  = 1'b0;
        end_drop    = 1'b0;
        csum_good   = 1'b0;
        case (state_q)
            IDLE: begin
                if (push) begin
                    if (admit) begin
                        fifo_we     = 1'b1;
                        start_frame = 1'b1;
                        // A lone word is its own checksum over zero prior words.
                        if (bus.ENDWORD) begin
                            end_accept = 1'b1;
                            csum_good  = (bus.DIN == 16'h0000);
                        end
                    end else if (bus.ENDWORD) begin
                        end_drop = 1'b1;
                    end
                end
            end
            RECV: begin
                if (push) begin
                    fifo_we    = 1'b1;
                    cont_frame = 1'b1;
                    if (bus.ENDWORD) begin
                        end_accept = 1'b1;
                        csum_good  = (bus.DIN == chk_q);
                    end
                end
            end
            DISCARD: begin
                end_drop = push && bus.ENDWORD;
            end
            default: ;
        endcase
    end

    // Running XOR of the words of the frame being received.
    always_ff @(posedge CLK) begin
        if (RST)              chk_q <= '0;
        else if (start_frame) chk_q <= bus.DIN;
        else if (cont_frame)  chk_q <= chk_q ^ bus.DIN;
    end

    // Frame-end pulses, one cycle after the ENDWORD push, and accepted-frame count.
    always_ff @(posedge CLK) begin
        if (RST) begin
            FRAME_OK  <= 1'b0;
            CRC_ERR   <= 1'b0;
            DROP      <= 1'b0;
            FRAME_CNT <= '0;
        end else begin
            FRAME_OK <= end_accept && csum_good;
            CRC_ERR  <= end_accept && !csum_good;
            DROP     <= end_drop;
            if (end_accept) FRAME_CNT <= FRAME_CNT + 8'd1;
        end
    end

`ifdef CFEB_RX_LENCHK_EN
    localparam logic [15:0] EXP_W = 16'(EXP_WORDS);

    logic [15:0] len_q;
    logic [15:0] len_d;

    // Words of the current frame including this cycle's push.
    always_comb begin
        len_d = len_q;
        if (start_frame)     len_d = 16'd1;
        else if (cont_frame) len_d = len_q + 16'd1;
    end

    // Length register and LEN_ERR pulse aligned with FRAME_OK/CRC_ERR.
    always_ff @(posedge CLK) begin
        if (RST) begin
            len_q   <= '0;
            LEN_ERR <= 1'b0;
        end else begin
            len_q   <= len_d;
            LEN_ERR <= end_accept && (len_d != EXP_W);
        end
    end
`endif

endmodule

// File: tb/tb_cfeb_dmb_rx.sv
// Directed bench for cfeb_dmb_rx with hand-computed expectations.
module tb_cfeb_dmb_rx;

    localparam int ADDR_W    = 11;
    localparam int MAX_WORDS = 1540;
`ifdef CFEB_RX_LENCHK_EN
    localparam int EXP_WORDS = 4;
    logic LEN_ERR;
`endif

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       FRAME_OK;
    logic       CRC_ERR;
    logic       DROP;
    logic [7:0] FRAME_CNT;

    int n_chk  = 0;
    int n_pass = 0;

    cfeb_dmb_rx_if bus();

    cfeb_dmb_rx #(
        .ADDR_W    (ADDR_W),
        .MAX_WORDS (MAX_WORDS)
`ifdef CFEB_RX_LENCHK_EN
        ,
        .EXP_WORDS (EXP_WORDS)
`endif
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .bus       (bus),
        .FRAME_OK  (FRAME_OK),
        .CRC_ERR   (CRC_ERR),
        .DROP      (DROP),
        .FRAME_CNT (FRAME_CNT)
`ifdef CFEB_RX_LENCHK_EN
        ,
        .LEN_ERR   (LEN_ERR)
`endif
    );

    initial begin
        forever #5 CLK = ~CLK;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic push_word(input logic [15:0] d, input logic e);
        bus.LPUSH_B = 1'b0;
        bus.DIN     = d;
        bus.ENDWORD = e;
        tick();
        bus.LPUSH_B = 1'b1;
        bus.ENDWORD = 1'b0;
    endtask

    task automatic read_word(output logic [15:0] d, output logic l);
        bus.RD_EN = 1'b1;
        tick();
        bus.RD_EN = 1'b0;
        d = bus.DOUT;
        l = bus.DOUT_LAST;
    endtask

    // n-word frame: words base, base+1, ... then their XOR as checksum.
    task automatic send_frame(input int n, input int base);
        logic [15:0] x;
        x = '0;
        for (int i = 0; i < n - 1; i++) begin
            push_word(16'(base + i), 1'b0);
            x = x ^ 16'(base + i);
        end
        push_word(x, 1'b1);
    endtask

    task automatic drain_frame(input int n, input int base, output int errs);
        logic [15:0] x;
        logic [15:0] d;
        logic        l;
        x    = '0;
        errs = 0;
        for (int i = 0; i < n; i++) begin
            read_word(d, l);
            if (i < n - 1) begin
                if (d !== 16'(base + i) || l !== 1'b0) errs++;
                x = x ^ 16'(base + i);
            end else begin
                if (d !== x || l !== 1'b1) errs++;
            end
        end
    endtask

    logic [15:0] rd_d;
    logic        rd_l;
    logic [15:0] exp_w [4];
    int          errs;
    int          full_seen;
    logic [15:0] xs;
    logic [15:0] prev;
    logic [15:0] w;

    initial begin
        bus.DIN     = '0;
        bus.LPUSH_B = 1'b1;
        bus.ENDWORD = 1'b0;
        bus.RD_EN   = 1'b0;
        RST         = 1'b1;
        tick();
        tick();
        check_eq("rst_empty",     bus.EMPTY,     1);
        check_eq("rst_full",      bus.FULL,      0);
        check_eq("rst_dout",      bus.DOUT,      0);
        check_eq("rst_dout_last", bus.DOUT_LAST, 0);
        check_eq("rst_frame_ok",  FRAME_OK,      0);
        check_eq("rst_crc_err",   CRC_ERR,       0);
        check_eq("rst_drop",      DROP,          0);
        check_eq("rst_frame_cnt", FRAME_CNT,     0);
        RST = 1'b0;

        // ENDWORD without a push is ignored.
        bus.ENDWORD = 1'b1;
        tick();
        bus.ENDWORD = 1'b0;
        tick();
        check_eq("nopush_end_ok",    FRAME_OK,  0);
        check_eq("nopush_end_drop",  DROP,      0);
        check_eq("nopush_end_empty", bus.EMPTY, 1);

        // Basic good frame.
        push_word(16'h0001, 1'b0);
        check_eq("wr_latency_empty", bus.EMPTY, 0);
        push_word(16'h0002, 1'b0);
        push_word(16'h0004, 1'b0);
        check_eq("basic_no_early_ok", FRAME_OK, 0);
        push_word(16'h0007, 1'b1);
        check_eq("basic_frame_ok", FRAME_OK,  1);
        check_eq("basic_crc_err",  CRC_ERR,   0);
        check_eq("basic_cnt",      FRAME_CNT, 1);
        tick();
        check_eq("basic_ok_pulse_width", FRAME_OK, 0);
        exp_w = '{16'h0001, 16'h0002, 16'h0004, 16'h0007};
        for (int i = 0; i < 4; i++) begin
            read_word(rd_d, rd_l);
            check_eq($sformatf("basic_rd%0d", i),      rd_d, exp_w[i]);
            check_eq($sformatf("basic_last%0d", i),    rd_l, (i == 3) ? 1 : 0);
        end
        check_eq("basic_empty_after", bus.EMPTY, 1);

        // Bad checksum: still stored and counted.
        push_word(16'h0001, 1'b0);
        push_word(16'h0002, 1'b0);
        push_word(16'h0004, 1'b0);
        push_word(16'h0006, 1'b1);
        check_eq("bad_crc_err",  CRC_ERR,   1);
        check_eq("bad_frame_ok", FRAME_OK,  0);
        check_eq("bad_cnt",      FRAME_CNT, 2);
        exp_w = '{16'h0001, 16'h0002, 16'h0004, 16'h0006};
        for (int i = 0; i < 4; i++) begin
            read_word(rd_d, rd_l);
            check_eq($sformatf("bad_rd%0d", i),   rd_d, exp_w[i]);
            check_eq($sformatf("bad_last%0d", i), rd_l, (i == 3) ? 1 : 0);
        end
        check_eq("bad_empty_after", bus.EMPTY, 1);

        // Preload 600 words, then a frame arrives with free=1448 and is dropped.
        send_frame(600, 1);
        check_eq("preload_ok",  FRAME_OK,  1);
        check_eq("preload_cnt", FRAME_CNT, 3);
        push_word(16'hAAAA, 1'b0);
        check_eq("drop_first_no_pulse", DROP, 0);
        push_word(16'hBBBB, 1'b0);
        push_word(16'h1111, 1'b1);
        check_eq("drop_pulse",    DROP,      1);
        check_eq("drop_no_ok",    FRAME_OK,  0);
        check_eq("drop_no_crc",   CRC_ERR,   0);
        check_eq("drop_cnt_hold", FRAME_CNT, 3);
        tick();
        check_eq("drop_pulse_width", DROP, 0);
        drain_frame(600, 1, errs);
        check_eq("preload_data_errs", errs,      0);
        check_eq("preload_count_600", bus.EMPTY, 1);

        // Read while empty: ignored, DOUT holds, pointers do not move.
        prev = bus.DOUT;
        read_word(rd_d, rd_l);
        check_eq("empty_rd_hold", rd_d,      prev);
        check_eq("empty_rd_last", rd_l,      1);
        check_eq("empty_rd_empty", bus.EMPTY, 1);
        push_word(16'h0000, 1'b1);
        check_eq("single_ok",  FRAME_OK,  1);
        check_eq("single_cnt", FRAME_CNT, 4);
        read_word(rd_d, rd_l);
        check_eq("single_rd",   rd_d, 16'h0000);
        check_eq("single_last", rd_l, 1);

        // Admission boundary: free == MAX_WORDS admitted, free == MAX_WORDS-1 dropped.
        send_frame(508, 16'h2000);
        check_eq("bnd_pre_ok", FRAME_OK, 1);
        push_word(16'h0000, 1'b1);
        check_eq("bnd_1540_ok",   FRAME_OK, 1);
        check_eq("bnd_1540_drop", DROP,     0);
        push_word(16'h0005, 1'b1);
        check_eq("bnd_1539_drop", DROP,      1);
        check_eq("bnd_1539_ok",   FRAME_OK,  0);
        check_eq("bnd_cnt",       FRAME_CNT, 6);
        drain_frame(508, 16'h2000, errs);
        check_eq("bnd_data_errs", errs, 0);
        read_word(rd_d, rd_l);
        check_eq("bnd_single_rd",   rd_d, 16'h0000);
        check_eq("bnd_single_last", rd_l, 1);
        check_eq("bnd_empty",       bus.EMPTY, 1);

        // Concurrent read/write through a 1537-word frame.
        bus.RD_EN = 1'b1;
        xs        = '0;
        errs      = 0;
        full_seen = 0;
        prev      = '0;
        for (int i = 0; i < 1537; i++) begin
            w = (i < 1536) ? 16'(i * 3 + 5) : xs;
            if (i < 1536) xs = xs ^ w;
            push_word(w, (i == 1536) ? 1'b1 : 1'b0);
            if (i > 0 && (bus.DOUT !== prev || bus.DOUT_LAST !== 1'b0)) errs++;
            if (bus.FULL !== 1'b0) full_seen++;
            prev = w;
        end
        check_eq("conc_frame_ok",  FRAME_OK,  1);
        check_eq("conc_cnt",       FRAME_CNT, 7);
        check_eq("conc_order_errs", errs,     0);
        check_eq("conc_full_seen", full_seen, 0);
        tick();
        bus.RD_EN = 1'b0;
        check_eq("conc_last_data",  bus.DOUT,      xs);
        check_eq("conc_last_flag",  bus.DOUT_LAST, 1);
        check_eq("conc_empty",      bus.EMPTY,     1);

        // Reset after 10 pushes of an unfinished frame.
        for (int i = 0; i < 10; i++) push_word(16'(16'h0100 + i), 1'b0);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        check_eq("mrst_empty", bus.EMPTY, 1);
        check_eq("mrst_cnt",   FRAME_CNT, 0);
        check_eq("mrst_dout",  bus.DOUT,  0);
        push_word(16'h1234, 1'b0);
        push_word(16'h1234, 1'b1);
        check_eq("mrst_ok",      FRAME_OK,  1);
        check_eq("mrst_crc",     CRC_ERR,   0);
        check_eq("mrst_cnt_new", FRAME_CNT, 1);
        read_word(rd_d, rd_l);
        check_eq("mrst_rd0", rd_d, 16'h1234);
        read_word(rd_d, rd_l);
        check_eq("mrst_rd1",   rd_d, 16'h1234);
        check_eq("mrst_last1", rd_l, 1);

`ifdef CFEB_RX_LENCHK_EN
        // 5-word frame against EXP_WORDS=4: good checksum but wrong length.
        push_word(16'h0001, 1'b0);
        push_word(16'h0002, 1'b0);
        push_word(16'h0003, 1'b0);
        push_word(16'h0004, 1'b0);
        push_word(16'h0004, 1'b1);
        check_eq("len5_ok",  FRAME_OK, 1);
        check_eq("len5_err", LEN_ERR,  1);
        push_word(16'h0001, 1'b0);
        push_word(16'h0002, 1'b0);
        push_word(16'h0004, 1'b0);
        push_word(16'h0007, 1'b1);
        check_eq("len4_ok",  FRAME_OK, 1);
        check_eq("len4_err", LEN_ERR,  0);
        tick();
        check_eq("len_err_width", LEN_ERR, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/cfeb_dmb_rx.md
Name: cfeb_dmb_rx

Overview:
- Downstream consumer of the CFEB readout stream: OUT[15:0], LPUSH_B, ENDWORD.
- Captures each pushed word and delimits frames on ENDWORD.
- Verifies the trailing checksum word and buffers accepted frames in a synchronous FIFO for the DMB event builder.
- Admission control: a frame is accepted whole or dropped whole, never truncated.

Parameters:
- ADDR_W, 11, FIFO address width; depth = 2^ADDR_W entries of 17 bits.
- MAX_WORDS, 1540, maximum frame length including checksum; admission threshold.

Ports:
- CLK  input  1  25 ns system clock (clk25ns domain).
- RST  input  1  synchronous active-high reset.
- DIN  input  16  CFEB data word.
- LPUSH_B  input  1  active-low word strobe; one word per CLK while low.
- ENDWORD  input  1  high with the final (checksum) word of a frame.
- RD_EN  input  1  FIFO read request.
- DOUT  output  16  FIFO read data.
- DOUT_LAST  output  1  marks the checksum word of a frame.
- EMPTY  output  1  FIFO empty.
- FULL  output  1  FIFO full.
- FRAME_OK  output  1  one-cycle pulse: frame accepted, checksum good.
- CRC_ERR  output  1  one-cycle pulse: frame accepted, checksum bad.
- DROP  output  1  one-cycle pulse at ENDWORD of a rejected frame.
- FRAME_CNT  output  8  accepted-frame counter, wraps 255->0.

Behaviour:
- Push event: LPUSH_B==0 sampled on rising CLK. ENDWORD is ignored unless a push occurs in the same cycle.
- Reset: all outputs are reset to 0 except EMPTY=1. Pointers, checksum and FRAME_CNT are cleared; FSM goes to IDLE. A reset mid-frame discards the partially written frame: pointers clear, so those words are lost.
- FSM states: IDLE, RECV, DISCARD.
- IDLE, push with free >= MAX_WORDS (free = 2^ADDR_W - count):
  - write word, set chk = DIN;
  - go to RECV; if ENDWORD is also set, apply the ENDWORD rule instead.
- IDLE, push with free < MAX_WORDS: go to DISCARD; nothing is written.
- RECV, push without ENDWORD: write word, chk <= chk ^ DIN.
- RECV, push with ENDWORD:
  - write word with DOUT_LAST=1;
  - if DIN == chk (the XOR of all prior words in the frame), pulse FRAME_OK, else pulse CRC_ERR;
  - FRAME_CNT++ in both cases;
  - return to IDLE.
- Single-word frame (ENDWORD on the first push): the checksum compares against 0.
- DISCARD: consume pushes. On ENDWORD, pulse DROP and return to IDLE.
- Pulses assert in the cycle after the ENDWORD push.
- Write latency: a pushed word is visible in the FIFO (EMPTY deasserted) 1 cycle after the push.
- Read: on RD_EN && !EMPTY, DOUT/DOUT_LAST update on the next edge and hold otherwise. RD_EN while EMPTY is ignored, with no pointer change.
- Simultaneous read and write: both occur in the same cycle; count is unchanged; legal even when full.
- FULL is unreachable by construction under admission control. The FIFO write port still blocks writes when FULL as a safety guard.
- Pointers: ADDR_W+1 bits, wrap naturally. count = wptr - rptr, width ADDR_W+1.

Optional Feature:
- Macro: CFEB_RX_LENCHK_EN.
- When defined:
  - adds parameter EXP_WORDS (default 1537) and output LEN_ERR;
  - a frame whose accepted length != EXP_WORDS pulses LEN_ERR together with FRAME_OK/CRC_ERR;
  - the frame is still stored.
- When undefined: no length counter and no LEN_ERR port.

Decomposition:
- Package cfeb_rx_pkg:
  - FSM state enum (IDLE/RECV/DISCARD);
  - default ADDR_W, MAX_WORDS, EXP_WORDS;
  - 17-bit FIFO entry width constant.
- Sub-module cfeb_rx_fifo: synchronous FIFO with a registered read port.
  - Ports: CLK, RST, WE, WD[16:0], RE, RD[16:0], EMPTY, FULL, COUNT.
  - The parent contains the FSM, checksum and counters.

Test Plan:
- Basic frame: 4-word frame 0x0001, 0x0002, 0x0004, checksum 0x0007 with ENDWORD -> FRAME_OK pulse, FRAME_CNT=1, reads return the 4 words, DOUT_LAST only on 0x0007.
- Bad checksum: same frame with checksum 0x0006 -> CRC_ERR pulse, FRAME_CNT=1, all 4 words stored.
- Admission drop: ADDR_W=11, preload 600 words unread, then a frame arrives -> free=1448<1540 -> DROP pulse, count stays 600, FRAME_CNT unchanged.
- Concurrent read and write: RD_EN held high during a 1537-word frame -> count never exceeds 1, data order preserved, no FULL.
- Mid-frame reset: RST asserted after 10 pushes -> next cycle EMPTY=1, FSM in IDLE; a new 2-word frame 0x1234, 0x1234 -> FRAME_OK.
- Lengthcheck (CFEB_RX_LENCHK_EN, EXP_WORDS=4): a 5-word frame with a valid checksum -> FRAME_OK and LEN_ERR pulse together.
